// File: rtl/spi_slv_pkg.sv
// Shared frame constants and FSM state type for the SPI register responder.
package spi_slv_pkg;

    localparam int   FRAME_LEN = 32;
    localparam int   ADDR_W    = 15;
    localparam int   DATA_W    = 16;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CMD_ADDR,
        DATA,
        DONE
    } state_e;

endpackage

// File: rtl/spi_slave_regs_if.sv
// SPI pin bundle between the FPGA master and the register responder.
interface spi_slave_regs_if;

    logic sclk;
    logic ss_n;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output sclk, ss_n, mosi,
        input  miso, miso_oe
    );

    modport slave (
        input  sclk, ss_n, mosi,
        output miso, miso_oe
    );

endinterface

// File: rtl/spi_slv_sync.sv
// Brings the asynchronous SPI pins into clk and produces single-cycle sclk edge pulses.
module spi_slv_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_n_s,
    output logic mosi_s
);

    logic [2:0] sclk_q, sclk_d;
    logic [1:0] ss_n_q, ss_n_d;
    logic [1:0] mosi_q, mosi_d;

    always_comb begin
        sclk_d = {sclk_q[1:0], sclk};
        ss_n_d = {ss_n_q[0], ss_n};
        mosi_d = {mosi_q[0], mosi};
    end

    // ss_n resets deselected so a reset never looks like the start of a frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q <= '0;
            ss_n_q <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= sclk_d;
            ss_n_q <= ss_n_d;
            mosi_q <= mosi_d;
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_n_s    = ss_n_q[1];
    assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder decoding 32-bit frames into a bank of 16-bit registers.
// Optional aborted-frame counter enabled by SPI_SLV_ERRCNT_EN.
//   state    | meaning
//   IDLE     | waiting for ss_n low, bit counter cleared
//   CMD_ADDR | shifting in cmd + 15-bit address (rises 1..16)
//   DATA     | shifting data in and read data out (rises 17..32)
//   DONE     | frame complete, sclk ignored until ss_n high
module spi_slave_regs
    import spi_slv_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 15'h0000,
    parameter int                N_REGS     = 32,
    parameter int                ADDR_LSB_W = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    spi_slave_regs_if.slave         spi,
    output logic [N_REGS*16-1:0]    regs_o,
    output logic                    wr_strb,
    output logic [ADDR_LSB_W-1:0]   wr_idx
`ifdef SPI_SLV_ERRCNT_EN
    ,
    output logic [DATA_W-1:0]       err_cnt
`endif
);

    logic sclk_rise, sclk_fall, ss_n_s, mosi_s;

    spi_slv_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk      (spi.sclk),
        .ss_n      (spi.ss_n),
        .mosi      (spi.mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_n_s    (ss_n_s),
        .mosi_s    (mosi_s)
    );

    state_e                        state_q, state_d;
    logic [5:0]                    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]             shift_in_q, shift_in_d;
    logic [DATA_W-1:0]             shift_out_q, shift_out_d;
    logic                          cmd_q, cmd_d;
    logic                          hit_q, hit_d;
    logic                          rd_en_q, rd_en_d;
    logic [ADDR_LSB_W-1:0]         idx_q, idx_d;
    logic [ADDR_LSB_W-1:0]         wr_idx_q, wr_idx_d;
    logic                          miso_q, miso_d;
    logic                          wr_strb_q, wr_strb_d;
    logic [N_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                          abort;

    // word is the 16 bits completed by the current rise; offset wraps high when below BASE_ADDR
    logic [DATA_W-1:0] word;
    logic [ADDR_W:0]   offset;
    logic              reg_hit;

    assign word    = {shift_in_q, mosi_s};
    assign offset  = {1'b0, word[ADDR_W-1:0]} - {1'b0, BASE_ADDR};
    assign reg_hit = (offset < (ADDR_W+1)'(N_REGS));

`ifdef SPI_SLV_ERRCNT_EN
    logic [DATA_W-1:0] err_cnt_q, err_cnt_d;
    logic              err_sel_q, err_sel_d;
    logic              err_hit;
    logic              err_clr;

    assign err_hit = (offset == (ADDR_W+1)'(N_REGS));
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        cmd_d       = cmd_q;
        hit_d       = hit_q;
        rd_en_d     = rd_en_q;
        idx_d       = idx_q;
        miso_d      = miso_q;
        wr_strb_d   = 1'b0;
        wr_idx_d    = wr_idx_q;
        regs_d      = regs_q;
        abort       = 1'b0;
`ifdef SPI_SLV_ERRCNT_EN
        err_sel_d   = err_sel_q;
        err_clr     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                miso_d    = 1'b0;
                if (!ss_n_s) state_d = CMD_ADDR;
            end
            CMD_ADDR: begin
                if (ss_n_s) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    shift_in_d = word[DATA_W-2:0];
                    bit_cnt_d  = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'(DATA_W - 1)) begin
                        cmd_d       = word[DATA_W-1];
                        hit_d       = reg_hit;
                        idx_d       = offset[ADDR_LSB_W-1:0];
                        rd_en_d     = (word[DATA_W-1] != CMD_WRITE) && reg_hit;
                        shift_out_d = rd_en_d ? regs_q[offset[ADDR_LSB_W-1:0]] : '0;
`ifdef SPI_SLV_ERRCNT_EN
                        err_sel_d = err_hit;
                        if ((word[DATA_W-1] != CMD_WRITE) && err_hit) begin
                            rd_en_d     = 1'b1;
                            shift_out_d = err_cnt_q;
                        end
`endif
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (ss_n_s) begin
                    abort   = 1'b1;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (sclk_fall) begin
                        miso_d      = shift_out_q[DATA_W-1];
                        shift_out_d = {shift_out_q[DATA_W-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        shift_in_d = word[DATA_W-2:0];
                        bit_cnt_d  = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'(FRAME_LEN - 1)) begin
                            state_d = DONE;
                            if (cmd_q == CMD_WRITE && hit_q) begin
                                regs_d[idx_q] = word;
                                wr_strb_d     = 1'b1;
                                wr_idx_d      = idx_q;
                            end
`ifdef SPI_SLV_ERRCNT_EN
                            if (cmd_q == CMD_WRITE && err_sel_q) err_clr = 1'b1;
`endif
                        end
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (ss_n_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            cmd_q       <= 1'b0;
            hit_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            idx_q       <= '0;
            miso_q      <= 1'b0;
            wr_strb_q   <= 1'b0;
            wr_idx_q    <= '0;
            regs_q      <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            cmd_q       <= cmd_d;
            hit_q       <= hit_d;
            rd_en_q     <= rd_en_d;
            idx_q       <= idx_d;
            miso_q      <= miso_d;
            wr_strb_q   <= wr_strb_d;
            wr_idx_q    <= wr_idx_d;
            regs_q      <= regs_d;
        end
    end

`ifdef SPI_SLV_ERRCNT_EN
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr)                     err_cnt_d = '0;
        else if (abort && err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_q <= '0;
            err_sel_q <= 1'b0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_sel_q <= err_sel_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign spi.miso    = miso_q;
    assign spi.miso_oe = (state_q == DATA) && rd_en_q;
    assign regs_o      = regs_q;
    assign wr_strb     = wr_strb_q;
    assign wr_idx      = wr_idx_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: writes/reads via bit-banged SPI, scoreboarded strobes and read data.
module tb_spi_slave_regs;
    import spi_slv_pkg::*;

    localparam int N_REGS     = 32;
    localparam int ADDR_LSB_W = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [N_REGS*16-1:0]  regs_o;
    logic                  wr_strb;
    logic [ADDR_LSB_W-1:0] wr_idx;
`ifdef SPI_SLV_ERRCNT_EN
    logic [15:0]           err_cnt;
`endif

    spi_slave_regs_if sif ();

    spi_slave_regs #(
        .BASE_ADDR  (15'h0000),
        .N_REGS     (N_REGS),
        .ADDR_LSB_W (ADDR_LSB_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .spi     (sif),
        .regs_o  (regs_o),
        .wr_strb (wr_strb),
        .wr_idx  (wr_idx)
`ifdef SPI_SLV_ERRCNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_strb = 0;
    logic [15:0] model [N_REGS];
    logic [20:0] wr_q [$];
    logic [15:0] rd_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        logic [N_REGS*16-1:0] exp;
        for (int i = 0; i < N_REGS; i++) exp[i*16 +: 16] = model[i];
        n_cmp++;
        assert (regs_o === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, regs_o, exp);
        end
    endtask

    // Write-strobe scoreboard: every strobe must match the oldest expected write
    always @(negedge clk) begin
        logic [20:0] e;
        if (wr_strb === 1'b1) begin
            n_strb++;
            if (wr_q.size() == 0) begin
                chk("unexpected_wr_strb", 32'(wr_idx), 32'hFFFF_FFFF);
            end else begin
                e = wr_q.pop_front();
                chk("wr_idx", 32'(wr_idx), 32'(e[20:16]));
                chk("wr_data", 32'(regs_o[32'(wr_idx)*16 +: 16]), 32'(e[15:0]));
            end
        end
    end

    // Mode-0 master at sclk = clk/8; miso/oe sampled at the end of each low phase
    task automatic run_frame(input logic [31:0] word, input int n_rises, input bit rst_mid,
                             input int gap, output logic [31:0] miso_bits,
                             output logic [31:0] oe_bits, output logic done_oe);
        miso_bits = '0;
        oe_bits   = '0;
        done_oe   = 1'b0;
        @(negedge clk);
        sif.ss_n = 1'b0;
        for (int i = 0; i < n_rises; i++) begin
            sif.mosi = word[31-i];
            repeat (4) @(negedge clk);
            miso_bits[31-i] = sif.miso;
            oe_bits[31-i]   = sif.miso_oe;
            sif.sclk = 1'b1;
            repeat (4) @(negedge clk);
            if (i == n_rises - 1) done_oe = sif.miso_oe;
            sif.sclk = 1'b0;
        end
        if (rst_mid) begin
            reset_n = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        sif.ss_n = 1'b1;
        sif.mosi = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic spi_write(input logic [14:0] addr, input logic [15:0] data, input int gap);
        logic [31:0] mb, ob;
        logic dn;
        if (32'(addr) < N_REGS) begin
            wr_q.push_back({addr[4:0], data});
            model[addr[4:0]] = data;
        end
        run_frame({1'b1, addr, data}, 32, 1'b0, gap, mb, ob, dn);
        chk("wr_frame_oe", ob, 32'h0);
    endtask

    task automatic spi_read(input logic [14:0] addr, input logic [15:0] exp, input bit exp_oe);
        logic [31:0] mb, ob;
        logic dn;
        logic [15:0] e;
        rd_q.push_back(exp);
        run_frame({1'b0, addr, 16'h0000}, 32, 1'b0, 4, mb, ob, dn);
        e = rd_q.pop_front();
        chk("rd_miso", mb, {16'h0000, e});
        chk("rd_oe", ob, exp_oe ? 32'h0000_FFFF : 32'h0);
        chk("rd_done_oe", 32'(dn), 32'h0);
    endtask

    initial begin
        logic [31:0] mb, ob;
        logic dn;
        sif.sclk = 1'b0;
        sif.ss_n = 1'b1;
        sif.mosi = 1'b0;
        for (int i = 0; i < N_REGS; i++) model[i] = 16'h0000;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        chk_regs("reset_regs");
        chk("reset_miso", 32'(sif.miso), 32'h0);
        chk("reset_oe", 32'(sif.miso_oe), 32'h0);
        chk("reset_wr_strb", 32'(wr_strb), 32'h0);
        chk("reset_wr_idx", 32'(wr_idx), 32'h0);
        chk("reset_state", 32'(dut.state_q), 32'(IDLE));
        chk("reset_bit_cnt", 32'(dut.bit_cnt_q), 32'h0);
`ifdef SPI_SLV_ERRCNT_EN
        chk("reset_err_cnt", 32'(err_cnt), 32'h0);
`endif

        spi_write(15'h0003, 16'hA5C3, 4);
        chk_regs("regs_after_wr3");
        chk("strb_count_1", 32'(n_strb), 32'd1);
        spi_read(15'h0003, 16'hA5C3, 1'b1);

        // write aborted after 20 rises must not land
        run_frame(32'h8003_1234, 20, 1'b0, 4, mb, ob, dn);
        chk_regs("regs_after_abort");
        chk("strb_count_abort", 32'(n_strb), 32'd1);
        chk("state_after_abort", 32'(dut.state_q), 32'(IDLE));
        spi_write(15'h0003, 16'h1234, 4);
        chk_regs("regs_after_rewrite");
        chk("strb_count_2", 32'(n_strb), 32'd2);

        spi_write(15'h0040, 16'hFFFF, 4);
        chk_regs("regs_after_miss_wr");
        chk("strb_count_miss", 32'(n_strb), 32'd2);
        spi_read(15'h0040, 16'h0000, 1'b0);

        // range edges with the minimum 2-clk deselect between frames
        spi_write(15'h001F, 16'h8001, 2);
        spi_write(15'h0000, 16'h7E5A, 2);
        chk_regs("regs_after_edges");
        chk("strb_count_edges", 32'(n_strb), 32'd4);
        spi_read(15'h001F, 16'h8001, 1'b1);
        spi_read(15'h0000, 16'h7E5A, 1'b1);
`ifndef SPI_SLV_ERRCNT_EN
        spi_read(15'h0020, 16'h0000, 1'b0);
        spi_write(15'h0020, 16'hBEEF, 4);
        chk_regs("regs_after_wr_0x20");
`endif

        run_frame(32'h8005_BEEF, 24, 1'b1, 0, mb, ob, dn);
        for (int i = 0; i < N_REGS; i++) model[i] = 16'h0000;
        chk_regs("regs_in_reset");
        chk("rst_miso", 32'(sif.miso), 32'h0);
        chk("rst_oe", 32'(sif.miso_oe), 32'h0);
        chk("rst_wr_strb", 32'(wr_strb), 32'h0);
        chk("rst_wr_idx", 32'(wr_idx), 32'h0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        spi_write(15'h0001, 16'h0055, 4);
        chk_regs("regs_after_reset_wr");
        chk("wr_idx_hold", 32'(wr_idx), 32'd1);

`ifdef SPI_SLV_ERRCNT_EN
        chk("errcnt_after_reset", 32'(err_cnt), 32'h0);
        run_frame(32'h0003_0000, 5, 1'b0, 4, mb, ob, dn);
        run_frame(32'h8002_1111, 20, 1'b0, 4, mb, ob, dn);
        run_frame(32'h0000_0000, 10, 1'b0, 4, mb, ob, dn);
        chk("errcnt_3", 32'(err_cnt), 32'd3);
        spi_read(15'h0020, 16'h0003, 1'b1);
        spi_write(15'h0020, 16'h0000, 4);
        chk("errcnt_cleared", 32'(err_cnt), 32'h0);
        chk_regs("regs_after_errclr");
`endif
        chk("strb_total", 32'(n_strb), 32'd5);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
